// File: rtl/mem_word_ctrl.sv
// mem_word_ctrl
//   Turns 16-bit (2*DATA_WIDTH) word requests into accesses on a byte-read,
//   word-write data memory. A write is issued as one word-wide memory write.
//   A read fetches the low byte, then the high byte, from the synchronous
//   byte-read port and returns the assembled word.
//
//   Optional build macro: MEM_WORD_CTRL_ALIGN_CHECK_EN
//     When defined, any request with req_addr[0]=1 is rejected. It performs no
//     memory access and answers with rsp_err=1 and rsp_rdata=0.
//     When undefined, odd addresses are serviced and rsp_err is tied to 0.
//
// Ports
//   clk, rst    clock, asynchronous active-high reset
//   req_*       request channel (valid/ready); req_we selects write or read
//   rsp_*       response channel (valid/ready); read word and error flag
//   mem_we, mem_w_addr, mem_w_data   word write port of the memory
//   mem_r_addr, mem_r_data           byte read port (data valid one cycle later)
module mem_word_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [2*DATA_WIDTH-1:0] req_wdata,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [2*DATA_WIDTH-1:0] rsp_rdata,
  output logic                    rsp_err,
  output logic                    mem_we,
  output logic [2*DATA_WIDTH-1:0] mem_w_data,
  output logic [ADDR_WIDTH-1:0]   mem_w_addr,
  output logic [ADDR_WIDTH-1:0]   mem_r_addr,
  input  logic [DATA_WIDTH-1:0]   mem_r_data
);

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_LO,
    RD_HI,
    RD_CAP,
    RESP
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic                    accept;
  logic                    misaligned;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [ADDR_WIDTH-1:0]   r_addr_q;
  logic [2*DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0]   lo_q;
  logic [2*DATA_WIDTH-1:0] rdata_q;

  assign accept = req_valid && (state == IDLE);

`ifdef MEM_WORD_CTRL_ALIGN_CHECK_EN
  logic err_q;
  assign misaligned = req_addr[0];
  assign rsp_err    = err_q;
`else
  assign misaligned = 1'b0;
  assign rsp_err    = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (misaligned)  state_nxt = RESP;
          else if (req_we) state_nxt = WR;
          else             state_nxt = RD_LO;
        end
      end
      WR:      state_nxt = IDLE;
      RD_LO:   state_nxt = RD_HI;
      RD_HI:   state_nxt = RD_CAP;
      RD_CAP:  state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // The read address is a register rather than a decode of the state.
  // This keeps it stable between reads and untouched by rejected requests.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q   <= '0;
      r_addr_q <= '0;
      wdata_q  <= '0;
      lo_q     <= '0;
      rdata_q  <= '0;
`ifdef MEM_WORD_CTRL_ALIGN_CHECK_EN
      err_q    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            if (misaligned) begin
              rdata_q <= '0;
`ifdef MEM_WORD_CTRL_ALIGN_CHECK_EN
              err_q   <= 1'b1;
`endif
            end else if (!req_we) begin
              r_addr_q <= req_addr;
            end
          end
        end
        RD_LO:  r_addr_q <= addr_q + ADDR_WIDTH'(1);
        RD_HI:  lo_q     <= mem_r_data;
        RD_CAP: begin
          rdata_q <= {mem_r_data, lo_q};
`ifdef MEM_WORD_CTRL_ALIGN_CHECK_EN
          err_q   <= 1'b0;
`endif
        end
        default: ;
      endcase
    end
  end

  assign req_ready  = (state == IDLE);
  assign rsp_valid  = (state == RESP);
  assign rsp_rdata  = rdata_q;
  assign mem_we     = (state == WR);
  assign mem_w_addr = addr_q;
  assign mem_w_data = wdata_q;
  assign mem_r_addr = r_addr_q;

endmodule

// File: tb/tb_mem_word_ctrl.sv
// Testbench for mem_word_ctrl (DATA_WIDTH=8, ADDR_WIDTH=8).
// The bench contains a byte memory that the DUT drives. The memory writes a
// word little-endian and reads a byte with one cycle of latency. A separate
// expected-contents array records what each accepted write should have left
// in memory. Read words, latencies and memory contents are checked against
// that array.
module tb_mem_word_ctrl;

`ifdef MEM_WORD_CTRL_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [7:0]  req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_we;
  logic [15:0] mem_w_data;
  logic [7:0]  mem_w_addr;
  logic [7:0]  mem_r_addr;
  logic [7:0]  mem_r_data;

  logic [7:0]  mem     [256];
  logic [7:0]  exp_mem [256];
  logic [7:0]  w_addr_p1;

  int unsigned checks;
  int unsigned failures;

  mem_word_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_we     (mem_we),
    .mem_w_data (mem_w_data),
    .mem_w_addr (mem_w_addr),
    .mem_r_addr (mem_r_addr),
    .mem_r_data (mem_r_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign w_addr_p1 = mem_w_addr + 8'd1;

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_w_addr] <= mem_w_data[7:0];
      mem[w_addr_p1]  <= mem_w_data[15:8];
    end
    mem_r_data <= mem[mem_r_addr];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_junk();
    req_valid = 1'($urandom_range(0, 1));
    req_we    = 1'($urandom_range(0, 1));
    req_addr  = 8'($urandom);
    req_wdata = 16'($urandom);
  endtask

  task automatic do_write(input logic [7:0] a, input logic [15:0] d);
    logic [7:0] a1;
    logic       err_exp;
    a1      = a + 8'd1;
    err_exp = ALIGN_EN && a[0];
    @(negedge clk);
    check_eq("wr_req_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
    @(negedge clk);
    drive_junk();
    if (err_exp) begin
      check_eq("wr_err_valid", 32'(rsp_valid), 32'd1);
      check_eq("wr_err_flag", 32'(rsp_err), 32'd1);
      check_eq("wr_err_rdata", 32'(rsp_rdata), 32'd0);
      check_eq("wr_err_no_we", 32'(mem_we), 32'd0);
      req_valid = 1'b0; rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check_eq("wr_err_idle", 32'(req_ready), 32'd1);
    end else begin
      check_eq("wr_we", 32'(mem_we), 32'd1);
      check_eq("wr_addr", 32'(mem_w_addr), 32'(a));
      check_eq("wr_data", 32'(mem_w_data), 32'(d));
      check_eq("wr_no_rsp", 32'(rsp_valid), 32'd0);
      exp_mem[a]  = d[7:0];
      exp_mem[a1] = d[15:8];
      @(negedge clk);
      req_valid = 1'b0;
      check_eq("wr_we_pulse", 32'(mem_we), 32'd0);
      check_eq("wr_back_idle", 32'(req_ready), 32'd1);
    end
    check_eq("wr_mem_lo", 32'(mem[a]), 32'(exp_mem[a]));
    check_eq("wr_mem_hi", 32'(mem[a1]), 32'(exp_mem[a1]));
  endtask

  task automatic do_read(input logic [7:0] a, input int unsigned stall);
    logic [7:0]  a1;
    logic [7:0]  ra_before;
    logic [15:0] exp;
    logic        err_exp;
    logic        we_seen;
    int unsigned lat;
    a1      = a + 8'd1;
    err_exp = ALIGN_EN && a[0];
    exp     = err_exp ? 16'h0 : {exp_mem[a1], exp_mem[a]};
    @(negedge clk);
    ra_before = mem_r_addr;
    check_eq("rd_req_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = 1'b0; req_addr = a; req_wdata = 16'($urandom);
    rsp_ready = 1'b0;
    lat = 0;
    we_seen = 1'b0;
    do begin
      @(negedge clk);
      lat++;
      if (mem_we) we_seen = 1'b1;
      drive_junk();
    end while (!rsp_valid && lat < 8);
    check_eq("rd_latency", lat, err_exp ? 32'd1 : 32'd4);
    check_eq("rd_no_mem_we", 32'(we_seen), 32'd0);
    check_eq("rd_rdata", 32'(rsp_rdata), 32'(exp));
    check_eq("rd_err", 32'(rsp_err), 32'(err_exp));
    check_eq("rd_busy", 32'(req_ready), 32'd0);
    if (err_exp) check_eq("rd_err_raddr_held", 32'(mem_r_addr), 32'(ra_before));
    for (int unsigned i = 0; i < stall; i++) begin
      @(negedge clk);
      drive_junk();
      check_eq("stall_valid", 32'(rsp_valid), 32'd1);
      check_eq("stall_rdata", 32'(rsp_rdata), 32'(exp));
      check_eq("stall_busy", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check_eq("rd_done_valid", 32'(rsp_valid), 32'd0);
    check_eq("rd_done_idle", 32'(req_ready), 32'd1);
    check_eq("rd_hold_rdata", 32'(rsp_rdata), 32'(exp));
  endtask

  task automatic reset_mid_read(input logic [7:0] a);
    logic seen;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = a; req_wdata = 16'h0;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("rst_req_ready", 32'(req_ready), 32'd1);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    check_eq("rst_rsp_err", 32'(rsp_err), 32'd0);
    check_eq("rst_mem_we", 32'(mem_we), 32'd0);
    check_eq("rst_mem_w_data", 32'(mem_w_data), 32'd0);
    check_eq("rst_mem_w_addr", 32'(mem_w_addr), 32'd0);
    check_eq("rst_mem_r_addr", 32'(mem_r_addr), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int unsigned i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid || mem_we) seen = 1'b1;
    end
    check_eq("rst_dropped", 32'(seen), 32'd0);
  endtask

  initial begin
    logic [7:0] a;
    checks = 0;
    failures = 0;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 8'($urandom);
      exp_mem[i] = mem[i];
    end
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b0;
    @(posedge clk);
    #1;
    check_eq("init_req_ready", 32'(req_ready), 32'd1);
    check_eq("init_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("init_rsp_rdata", 32'(rsp_rdata), 32'd0);
    check_eq("init_mem_we", 32'(mem_we), 32'd0);
    check_eq("init_mem_r_addr", 32'(mem_r_addr), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    do_write(8'h40, 16'h1234);
    do_read(8'h40, 0);
    do_write(8'hFF, 16'hBEEF);
    check_eq("wrap_byte_ff", 32'(mem[255]), 32'h00EF);
    check_eq("wrap_byte_00", 32'(mem[0]), 32'h00BE);
    do_read(8'hFF, 1);
    do_read(8'h40, 3);
    reset_mid_read(8'h40);
    do_read(8'h40, 0);
    do_read(8'h41, 1);
    do_write(8'h41, 16'h5AA5);
    do_read(8'h42, 0);

    for (int unsigned n = 0; n < 60; n++) begin
      a = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
      if ($urandom_range(0, 1) == 1) do_write(a, 16'($urandom));
      else                           do_read(a, $urandom_range(0, 3));
    end

    for (int i = 0; i < 256; i++) begin
      if (mem[i] !== exp_mem[i]) begin
        failures++;
        $display("FAIL final_mem[%0d]: got 0x%0h expected 0x%0h", i, mem[i], exp_mem[i]);
      end
    end
    checks++;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_word_ctrl.md
MEM_WORD_CTRL -- requirements
Module: mem_word_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: byte width of the attached data memory.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8: byte-address width of the attached data memory.
REQ-003 clk  in  1  single clock; all state SHALL update on posedge clk.
REQ-004 rst  in  1  reset; SHALL be asynchronous and active-high.
REQ-005 req_valid  in  1  client request present.
REQ-006 req_ready  out  1  controller can accept a request.
REQ-007 req_we  in  1  1 = write word, 0 = read word.
REQ-008 req_addr  in  ADDR_WIDTH  byte address of low byte.
REQ-009 req_wdata  in  2*DATA_WIDTH  write word, little-endian.
REQ-010 rsp_valid  out  1  read response (or error) present.
REQ-011 rsp_ready  in  1  client accepts response.
REQ-012 rsp_rdata  out  2*DATA_WIDTH  assembled read word.
REQ-013 rsp_err  out  1  response carries an alignment error.
REQ-014 mem_we  out  1  memory write enable.
REQ-015 mem_w_data  out  2*DATA_WIDTH  memory write word.
REQ-016 mem_w_addr  out  ADDR_WIDTH  memory write address.
REQ-017 mem_r_addr  out  ADDR_WIDTH  memory read address.
REQ-018 mem_r_data  in  DATA_WIDTH  memory read byte, valid one cycle after mem_r_addr is presented with mem_we=0.

Function
REQ-019 FSM states SHALL be IDLE, WR, RD_LO, RD_HI, RD_CAP, RESP.
REQ-020 req_ready SHALL be 1 only in IDLE; handshake = req_valid & req_ready latches req_we/req_addr/req_wdata.
REQ-021 IDLE: handshake with req_we=1 -> WR; with req_we=0 -> RD_LO; otherwise stay.
REQ-022 WR: mem_we=1, mem_w_addr=latched addr, mem_w_data=latched wdata for exactly one cycle -> IDLE; no response is generated.
REQ-023 mem_we SHALL be 0 in every state except WR.
REQ-024 RD_LO: mem_r_addr=addr -> RD_HI.
REQ-025 RD_HI: mem_r_addr=addr+1 (modulo 2^ADDR_WIDTH); capture mem_r_data into low byte -> RD_CAP.
REQ-026 RD_CAP: capture mem_r_data into high byte -> RESP.
REQ-027 RESP: rsp_valid=1, rsp_rdata={high,low} held stable until rsp_valid & rsp_ready, then -> IDLE.
REQ-028 Read latency SHALL be 4 cycles from the accepting edge to rsp_valid; write occupies 1 cycle after acceptance.
REQ-029 req_valid while not in IDLE SHALL be ignored (no latch, no effect).
REQ-030 Address 2^ADDR_WIDTH-1 SHALL wrap: high byte from address 0.
REQ-031 rsp_rdata and rsp_err SHALL hold their last values outside RESP.

Reset
REQ-032 rst asserted SHALL immediately force IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_we=0, mem_w_data=0, mem_w_addr=0, mem_r_addr=0.
REQ-033 rst during any in-flight operation SHALL drop it with no response and no memory write.

Configuration
REQ-034 Macro MEM_WORD_CTRL_ALIGN_CHECK_EN defined: a request with req_addr[0]=1 SHALL perform no memory access; a read goes directly to RESP with rsp_err=1, rsp_rdata=0; a write is dropped and goes to RESP with rsp_err=1 (acknowledged error).
REQ-035 Macro undefined: odd addresses SHALL be processed normally and rsp_err SHALL be constant 0.

Verification
REQ-036 Write 0x1234 @0x40, then read 0x40 -> mem_we pulsed one cycle; rsp_valid 4 cycles after read acceptance, rsp_rdata=0x1234, rsp_err=0.
REQ-037 Write 0xBEEF @0xFF, read 0xFF -> memory bytes 0xFF=0xEF, 0x00=0xBE; rsp_rdata=0xBEEF.
REQ-038 Read with rsp_ready low 3 cycles -> rsp_valid and rsp_rdata stable, req_ready=0, new req_valid ignored; IDLE the cycle after rsp_ready=1.
REQ-039 Assert rst during RD_HI -> all outputs at reset values that cycle, no rsp_valid afterwards, next request serviced normally.
REQ-040 Read 0x41 with MEM_WORD_CTRL_ALIGN_CHECK_EN -> rsp_err=1, rsp_rdata=0, mem_r_addr unchanged; without the macro -> normal word {mem[0x42],mem[0x41]}, rsp_err=0.
